// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sweep checker.
package gray_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // True when exactly one bit of x is set; narrower callers zero-extend.
    function automatic logic hw_is_one(input logic [MAX_WIDTH-1:0] x);
        return (x != '0) && ((x & (x - MAX_WIDTH'(1))) == '0);
    endfunction

endpackage

// File: rtl/gray_roundtrip.sv
// Combinational binary -> Gray -> binary path used to self-check the encoder.
module gray_roundtrip #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] rec
);

    assign gray = bin ^ (bin >> 1);

    // Decode is a running XOR from the MSB down.
    always_comb begin
        rec            = '0;
        rec[WIDTH-1]   = gray[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            rec[i] = rec[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/gray_sweep_ctrl.sv
// Sweeps a binary range, checking Gray round-trip and single-bit adjacency per value.
module gray_sweep_ctrl
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    input  logic             dir,
    input  logic             fault_inj,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] cur_bin,
    output logic [WIDTH-1:0] cur_gray,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] fail_val
);

    localparam int unsigned CW = WIDTH + 1;

    state_t           state;
    logic [WIDTH-1:0] end_q;
    logic             dir_q;
    logic             first;
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] rec_bin;

    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] gray_next;
    logic [WIDTH-1:0] rec_next;
    logic [WIDTH-1:0] chk_bin;
    logic             val_fail;
    logic [CW-1:0]    err_next;

    // Encode the value about to be loaded so cur_gray stays a registered output.
    gray_roundtrip #(.WIDTH(WIDTH)) u_roundtrip (
        .bin  (next_bin),
        .gray (gray_next),
        .rec  (rec_next)
    );

    always_comb begin
        next_bin = cur_bin;
        if (state == IDLE && start) begin
            next_bin = start_val;
        end else if (state == RUN && cur_bin != end_q) begin
            next_bin = dir_q ? cur_bin - WIDTH'(1) : cur_bin + WIDTH'(1);
        end

        chk_bin  = rec_bin ^ WIDTH'(fault_inj);
        val_fail = (chk_bin != cur_bin) ||
                   (!first && !hw_is_one(MAX_WIDTH'(cur_gray ^ prev_gray)));
        err_next = err_count + CW'(val_fail);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid     <= 1'b0;
            cur_bin   <= '0;
            cur_gray  <= '0;
            rec_bin   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_val  <= '0;
            end_q     <= '0;
            dir_q     <= 1'b0;
            first     <= 1'b0;
            prev_gray <= '0;
        end else begin
            cur_bin  <= next_bin;
            cur_gray <= gray_next;
            rec_bin  <= rec_next;
            done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        end_q     <= end_val;
                        dir_q     <= dir;
                        err_count <= '0;
                        fail_val  <= '0;
                        pass      <= 1'b0;
                        first     <= 1'b1;
                        busy      <= 1'b1;
                        valid     <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    first     <= 1'b0;
                    prev_gray <= cur_gray;
                    err_count <= err_next;
                    // Only the first failing value is recorded.
                    if (val_fail && err_count == '0) begin
                        fail_val <= cur_bin;
                    end
                    if (cur_bin == end_q) begin
                        busy  <= 1'b0;
                        valid <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Self-checking bench for gray_sweep_ctrl against a sequence-level reference model.
module tb_gray_sweep_ctrl;

    localparam int unsigned W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] start_val = '0;
    logic [W-1:0] end_val = '0;
    logic         dir = 1'b0;
    logic         fault_inj = 1'b0;
    logic         busy;
    logic         valid;
    logic [W-1:0] cur_bin;
    logic [W-1:0] cur_gray;
    logic         done;
    logic         pass;
    logic [W:0]   err_count;
    logic [W-1:0] fail_val;

    int unsigned n_assert = 0;
    int unsigned n_fail = 0;

    gray_sweep_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_val (start_val),
        .end_val   (end_val),
        .dir       (dir),
        .fault_inj (fault_inj),
        .busy      (busy),
        .valid     (valid),
        .cur_bin   (cur_bin),
        .cur_gray  (cur_gray),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_val  (fail_val)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_valid"}, 32'(valid),     32'd0);
        check({tag, "_bin"},   32'(cur_bin),   32'd0);
        check({tag, "_gray"},  32'(cur_gray),  32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_pass"},  32'(pass),      32'd0);
        check({tag, "_errs"},  32'(err_count), 32'd0);
        check({tag, "_fval"},  32'(fail_val),  32'd0);
    endtask

    // Sweep model: value k of the sweep is start +/- k mod 2^W; a value fails iff
    // fault_inj is high while it is under check (a correct encoder never breaks adjacency).
    task automatic sweep(input int s, input int e, input int d,
                         input logic [M-1:0] fmask, input bit extra);
        int n, b, errs, fv;
        bit seen;
        logic [31:0] sv, ev;
        n    = d ? ((s - e + M) % M) + 1 : ((e - s + M) % M) + 1;
        errs = 0;
        fv   = 0;
        seen = 1'b0;
        sv   = 32'(s);
        ev   = 32'(e);
        start_val = sv[W-1:0];
        end_val   = ev[W-1:0];
        dir       = d[0];
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        start_val = W'($urandom_range(0, M - 1));
        end_val   = W'($urandom_range(0, M - 1));
        dir       = ~dir;
        for (int k = 0; k < n; k++) begin
            b = d ? (s + M - k) % M : (s + k) % M;
            sv = 32'(b);
            check("run_valid", 32'(valid),    32'd1);
            check("run_busy",  32'(busy),     32'd1);
            check("run_done",  32'(done),     32'd0);
            check("run_bin",   32'(cur_bin),  32'(b));
            check("run_gray",  32'(cur_gray), 32'(b ^ (b >> 1)));
            fault_inj = fmask[sv[W-1:0]];
            if (fault_inj) begin
                errs++;
                if (!seen) begin
                    fv   = b;
                    seen = 1'b1;
                end
            end
            start = extra && (k == 1 || k == n - 1);
            @(negedge clk);
        end
        fault_inj = 1'b0;
        start     = extra;
        check("done_pulse", 32'(done),      32'd1);
        check("done_busy",  32'(busy),      32'd0);
        check("done_valid", 32'(valid),     32'd0);
        check("done_pass",  32'(pass),      32'(errs == 0));
        check("done_errs",  32'(err_count), 32'(errs));
        check("done_fval",  32'(fail_val),  32'(fv));
        @(negedge clk);
        start = 1'b0;
        check("idle_done",  32'(done),      32'd0);
        check("idle_busy",  32'(busy),      32'd0);
        check("idle_valid", 32'(valid),     32'd0);
        check("idle_pass",  32'(pass),      32'(errs == 0));
        check("idle_errs",  32'(err_count), 32'(errs));
        check("idle_fval",  32'(fail_val),  32'(fv));
        @(negedge clk);
    endtask

    initial begin
        logic [M-1:0] mask;
        int s, e, d;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        sweep(0, 8, 0, '0, 1'b0);
        sweep(14, 1, 0, '0, 1'b0);
        sweep(5, 4, 0, '0, 1'b0);
        mask = '0;
        mask[2] = 1'b1;
        sweep(3, 0, 1, mask, 1'b0);
        sweep(7, 7, 1, '0, 1'b0);
        sweep(2, 9, 0, '0, 1'b1);
        sweep(1, 15, 1, '0, 1'b1);
        sweep(5, 4, 0, '1, 1'b0);
        sweep(9, 10, 1, '1, 1'b0);

        // Abort a sweep with reset at RUN cycle 3.
        start_val = W'(0);
        end_val   = W'(15);
        dir       = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("abort_bin", 32'(cur_bin), 32'(k));
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_nodone", 32'(done), 32'd0);
            check("abort_idle",   32'(busy), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_abort");
        sweep(4, 6, 0, '0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            s = $urandom_range(0, M - 1);
            e = $urandom_range(0, M - 1);
            d = $urandom_range(0, 1);
            for (int i = 0; i < M; i++) begin
                mask[i] = ($urandom_range(0, 4) == 0);
            end
            sweep(s, e, d, mask, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_sweep_ctrl.md
GRAY_SWEEP_CTRL -- requirements
Module: gray_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the code width in bits (2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a sweep; ignored while busy=1.
REQ-005 SHALL have port start_val, input, WIDTH, the first binary value of the sweep, sampled when start is accepted.
REQ-006 SHALL have port end_val, input, WIDTH, the last binary value of the sweep, sampled when start is accepted.
REQ-007 SHALL have port dir, input, 1, the sweep direction (0 = increment, 1 = decrement), sampled when start is accepted.
REQ-008 SHALL have port fault_inj, input, 1; while high, it inverts bit 0 of the recovered binary value before the compare (test hook).
REQ-009 SHALL have port busy, output, 1, high in RUN.
REQ-010 SHALL have port valid, output, 1, high when cur_bin/cur_gray hold the value under check.
REQ-011 SHALL have port cur_bin, output, WIDTH, the binary value under check.
REQ-012 SHALL have port cur_gray, output, WIDTH, equal to cur_bin ^ (cur_bin >> 1).
REQ-013 SHALL have port done, output, 1, a one-cycle pulse at sweep completion.
REQ-014 SHALL have port pass, output, 1, high when the last sweep had zero errors; held until the next accepted start.
REQ-015 SHALL have port err_count, output, WIDTH+1, the number of failing values in the current or last sweep.
REQ-016 SHALL have port fail_val, output, WIDTH, the first failing binary value, or 0 if none.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE: when start=1, SHALL load cur_bin=start_val, latch end_val and dir, clear err_count, fail_val and pass, and go to RUN.
REQ-019 RUN: each cycle SHALL check exactly one value; valid=1 and busy=1.
REQ-020 Roundtrip check: the recovered binary from cur_gray SHALL equal cur_bin, else the value fails.
REQ-021 Adjacency check: for every value except the first, cur_gray XOR the previous cur_gray SHALL have Hamming weight exactly 1, else the value fails.
REQ-022 A value failing both checks SHALL increment err_count once.
REQ-023 fail_val SHALL capture cur_bin at the first failure only.
REQ-024 If cur_bin==end_val, SHALL go to DONE; else cur_bin SHALL step by +1 (dir=0) or -1 (dir=1), modulo 2^WIDTH.
REQ-025 Wrap-around: an up-step from all-ones SHALL give 0, and a down-step from 0 SHALL give all-ones; the adjacency check applies across the wrap.
REQ-026 Sweep length SHALL be N = ((end_val - start_val) mod 2^WIDTH) + 1 for dir=0, and ((start_val - end_val) mod 2^WIDTH) + 1 for dir=1; RUN lasts exactly N cycles.
REQ-027 start_val==end_val SHALL give N=1; the full-circle case (e.g. up, end=start-1) SHALL give N=2^WIDTH with no err_count overflow.
REQ-028 DONE SHALL last one cycle: done=1, pass=(err_count==0) taking this cycle's final check into account, busy=0, valid=0; then go to IDLE.
REQ-029 start asserted in RUN or DONE SHALL be ignored with no side effects.
REQ-030 err_count, fail_val and pass SHALL remain stable in IDLE until the next accepted start.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IDLE and all outputs (busy, valid, cur_bin, cur_gray, done, pass, err_count, fail_val) to 0.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; release SHALL resume in IDLE.

Structure
REQ-033 Package gray_pkg SHALL hold the FSM state encoding localparams and the default WIDTH constant.
REQ-034 SHALL instantiate one combinational sub-module, gray_roundtrip (bin->gray->bin), to produce cur_gray and the recovered binary value.
REQ-035 SHALL implement the Hamming-weight-equals-one test as a shared function (x!=0 && (x&(x-1))==0).

Verification
REQ-036 WIDTH=4, start_val=0, end_val=8, dir=0 -> 9 RUN cycles, cur_gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100, then done=1, pass=1, err_count=0.
REQ-037 start_val=14, end_val=1, dir=0 -> cur_bin sequence 14,15,0,1, then done after 4 RUN cycles, pass=1.
REQ-038 start_val=5, end_val=4, dir=0 -> 16 RUN cycles, err_count=0, pass=1.
REQ-039 start_val=3, end_val=0, dir=1, fault_inj high only while cur_bin=2 -> err_count=1, fail_val=2, pass=0.
REQ-040 Extra start pulses during RUN are ignored -> sweep length unchanged.
REQ-041 rst_n pulsed low at RUN cycle 3 -> all outputs 0 immediately, no done pulse, and the next start works normally.
